// File: rtl/wdt_axi_reg.sv
// wdt_axi_reg: AXI4-Lite style register slave feeding the watchdog timer.
// Decodes bus writes into WDEN, WDLIVE and WTOCNT and returns WTO status on reads.
// Optional feature macro: WDT_READBACK_EN. When it is defined, WDEN and WTOCNT
// read back their current values. Without it those offsets read as zero with OKAY.
module wdt_axi_reg #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEC_BITS   = 16,
  parameter logic [31:0] WTOCNT_RST = 32'hFFFF_FFFF
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              WTO,
  output logic              WDEN,
  output logic              WDLIVE,
  output logic [31:0]       WTOCNT
);

  localparam logic [DEC_BITS-1:0] OFF_WDEN   = DEC_BITS'(16'h0100);
  localparam logic [DEC_BITS-1:0] OFF_WDLIVE = DEC_BITS'(16'h0200);
  localparam logic [DEC_BITS-1:0] OFF_WTOCNT = DEC_BITS'(16'h0300);
  localparam logic [DEC_BITS-1:0] OFF_STATUS = DEC_BITS'(16'h0400);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e             wstate_q, wstate_d;
  logic                aw_have_q, aw_have_d;
  logic                w_have_q, w_have_d;
  logic [DEC_BITS-1:0] awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                wden_q, wden_d;
  logic                wdlive_q, wdlive_d;
  logic [31:0]         wtocnt_q, wtocnt_d;

  rstate_e             rstate_q, rstate_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs;
  logic                w_hs;
  logic [DEC_BITS-1:0] eff_addr;
  logic [31:0]         eff_data;
  logic [3:0]          eff_strb;

  // Address bits above the decoded window carry no meaning for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_W-1:DEC_BITS], ARADDR[ADDR_W-1:DEC_BITS]};

  // Write channel: collect AW and W in any order, commit the register update on
  // the edge where both are present, then hold the response until BREADY.
  always_comb begin
    wstate_d  = wstate_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wden_d    = wden_q;
    wtocnt_d  = wtocnt_q;
    wdlive_d  = 1'b0;
    aw_hs     = (wstate_q == W_IDLE) && !aw_have_q && AWVALID;
    w_hs      = (wstate_q == W_IDLE) && !w_have_q && WVALID;
    eff_addr  = aw_have_q ? awaddr_q : AWADDR[DEC_BITS-1:0];
    eff_data  = w_have_q ? wdata_q : WDATA;
    eff_strb  = w_have_q ? wstrb_q : WSTRB;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = AWADDR[DEC_BITS-1:0];
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          wstate_d  = W_RESP;
          bresp_d   = RESP_OKAY;
          case (eff_addr)
            OFF_WDEN: begin
              if (eff_strb[0]) wden_d = eff_data[0];
            end
            OFF_WDLIVE: begin
              wdlive_d = eff_data[0] & eff_strb[0];
            end
            OFF_WTOCNT: begin
              for (int b = 0; b < 4; b++) begin
                if (eff_strb[b]) wtocnt_d[8*b +: 8] = eff_data[8*b +: 8];
              end
            end
            default: begin
              bresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      W_RESP: begin
        if (BREADY) wstate_d = W_IDLE;
      end
    endcase
  end

  // Write-side state and watchdog control registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      wden_q    <= 1'b0;
      wdlive_q  <= 1'b0;
      wtocnt_q  <= WTOCNT_RST;
    end else begin
      wstate_q  <= wstate_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      wden_q    <= wden_d;
      wdlive_q  <= wdlive_d;
      wtocnt_q  <= wtocnt_d;
    end
  end

  // Read channel: latch data and response at the AR handshake, hold until RREADY.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ARVALID) begin
          rstate_d = R_DATA;
          rresp_d  = RESP_OKAY;
          rdata_d  = '0;
          case (ARADDR[DEC_BITS-1:0])
            OFF_WDEN: begin
`ifdef WDT_READBACK_EN
              rdata_d = {31'b0, wden_q};
`else
              rdata_d = '0;
`endif
            end
            OFF_WTOCNT: begin
`ifdef WDT_READBACK_EN
              rdata_d = wtocnt_q;
`else
              rdata_d = '0;
`endif
            end
            OFF_STATUS: begin
              rdata_d = {31'b0, WTO};
            end
            default: begin
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (RREADY) rstate_d = R_IDLE;
      end
    endcase
  end

  // Read-side state and the held response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign AWREADY = (wstate_q == W_IDLE) && !aw_have_q;
  assign WREADY  = (wstate_q == W_IDLE) && !w_have_q;
  assign BVALID  = (wstate_q == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = (rstate_q == R_IDLE);
  assign RVALID  = (rstate_q == R_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign WDEN    = wden_q;
  assign WDLIVE  = wdlive_q;
  assign WTOCNT  = wtocnt_q;

endmodule

// File: tb/tb_wdt_axi_reg.sv
// Testbench for wdt_axi_reg: directed cases with literal expectations followed by
// randomized bus traffic checked against a transaction-level register model.
module tb_wdt_axi_reg;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        WTO;
  logic        WDEN;
  logic        WDLIVE;
  logic [31:0] WTOCNT;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          pulse_cycles = 0;
  logic        check_en = 1'b0;

  // Register model: what the watchdog controls must currently be.
  logic        m_wden = 1'b0;
  logic [31:0] m_wtocnt = 32'hFFFF_FFFF;
  logic        m_wdlive = 1'b0;

  wdt_axi_reg dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .WTO(WTO), .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one committed write to the model; returns the response and kick request.
  function automatic void modelWrite(input logic [15:0] off, input logic [31:0] data,
                                     input logic [3:0] strb, output logic [1:0] resp,
                                     output logic pulse);
    resp  = 2'b00;
    pulse = 1'b0;
    if (off == 16'h0100) begin
      if (strb[0]) m_wden = data[0];
    end else if (off == 16'h0200) begin
      pulse = data[0] && strb[0];
    end else if (off == 16'h0300) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_wtocnt[8*b +: 8] = data[8*b +: 8];
      end
    end else begin
      resp = 2'b10;
    end
  endfunction

  // Expected read result from the current model state and WTO.
  function automatic void modelRead(input logic [15:0] off, output logic [31:0] data,
                                    output logic [1:0] resp);
    resp = 2'b00;
    data = 32'h0;
    if (off == 16'h0100) begin
`ifdef WDT_READBACK_EN
      data = {31'b0, m_wden};
`endif
    end else if (off == 16'h0300) begin
`ifdef WDT_READBACK_EN
      data = m_wtocnt;
`endif
    end else if (off == 16'h0400) begin
      data = {31'b0, WTO};
    end else begin
      resp = 2'b10;
    end
  endfunction

  // Per-cycle comparison of the watchdog-facing outputs against the model.
  always @(negedge ACLK) begin
    if (check_en) begin
      checkOutput("wden", {31'b0, WDEN}, {31'b0, m_wden});
      checkOutput("wtocnt", WTOCNT, m_wtocnt);
      checkOutput("wdlive", {31'b0, WDLIVE}, {31'b0, m_wdlive});
    end
  end

  always @(posedge ACLK) begin
    if (WDLIVE) pulse_cycles++;
  end

  // One write transaction; AW and W each launch after their own delay.
  task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input int bready_delay,
                          output logic [1:0] got_resp);
    logic       aw_done;
    logic       w_done;
    logic [1:0] e_resp;
    logic       e_pulse;
    int         cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    got_resp = 2'bxx;
    while (!(aw_done && w_done)) begin
      AWVALID = !aw_done && (cyc >= aw_delay);
      WVALID  = !w_done && (cyc >= w_delay);
      if (AWVALID) AWADDR = addr;
      if (WVALID) begin
        WDATA = data;
        WSTRB = strb;
      end
      @(negedge ACLK);
      checkOutput("awready", {31'b0, AWREADY}, {31'b0, !aw_done});
      checkOutput("wready", {31'b0, WREADY}, {31'b0, !w_done});
      checkOutput("bvalid_early", {31'b0, BVALID}, 32'd0);
      @(posedge ACLK);
      #1;
      if (AWVALID) aw_done = 1'b1;
      if (WVALID) w_done = 1'b1;
      cyc++;
    end
    modelWrite(addr[15:0], data, strb, e_resp, e_pulse);
    m_wdlive = e_pulse;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    AWADDR  = $urandom;
    WDATA   = $urandom;
    for (int k = 0; k <= bready_delay; k++) begin
      BREADY = (k == bready_delay);
      @(negedge ACLK);
      checkOutput("bvalid", {31'b0, BVALID}, 32'd1);
      checkOutput("bresp", {30'b0, BRESP}, {30'b0, e_resp});
      checkOutput("awready_busy", {31'b0, AWREADY}, 32'd0);
      got_resp = BRESP;
      @(posedge ACLK);
      #1;
      m_wdlive = 1'b0;
    end
    BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("bvalid_done", {31'b0, BVALID}, 32'd0);
    checkOutput("awready_idle", {31'b0, AWREADY}, 32'd1);
    checkOutput("wready_idle", {31'b0, WREADY}, 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  // One read transaction; the expectation is taken from the model just before the handshake edge.
  task automatic readTxn(input logic [31:0] addr, input int ar_delay, input int rready_delay,
                         output logic [31:0] got_data, output logic [1:0] got_resp);
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    got_data = 'x;
    got_resp = 'x;
    repeat (ar_delay) begin
      @(negedge ACLK);
      checkOutput("rvalid_idle", {31'b0, RVALID}, 32'd0);
      @(posedge ACLK);
      #1;
    end
    ARADDR  = addr;
    ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("arready", {31'b0, ARREADY}, 32'd1);
    modelRead(addr[15:0], e_data, e_resp);
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    for (int k = 0; k <= rready_delay; k++) begin
      RREADY = (k == rready_delay);
      @(negedge ACLK);
      checkOutput("rvalid", {31'b0, RVALID}, 32'd1);
      checkOutput("rdata", RDATA, e_data);
      checkOutput("rresp", {30'b0, RRESP}, {30'b0, e_resp});
      checkOutput("arready_busy", {31'b0, ARREADY}, 32'd0);
      got_data = RDATA;
      got_resp = RRESP;
      @(posedge ACLK);
      #1;
    end
    RREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalid_done", {31'b0, RVALID}, 32'd0);
    checkOutput("arready_idle", {31'b0, ARREADY}, 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  // One random operation: a write, a read, or both launched to meet on the same edge.
  task automatic applyStimulus();
    logic [15:0] offs [6];
    logic [31:0] addr;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    int          kind;
    int          d;
    offs = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0000};
    addr = {16'($urandom), offs[$urandom_range(0, 5)]};
    if ($urandom_range(0, 7) == 0) addr[15:0] = 16'($urandom);
    kind = $urandom_range(0, 2);
    WTO  = 1'($urandom);
    if (kind == 0) begin
      writeTxn(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), br);
    end else if (kind == 1) begin
      readTxn(addr, $urandom_range(0, 2), $urandom_range(0, 3), rd, rr);
    end else begin
      d = $urandom_range(0, 2);
      fork
        writeTxn(addr, $urandom, 4'($urandom), d, d, $urandom_range(0, 2), br);
        readTxn({16'($urandom), offs[$urandom_range(0, 5)]}, d, $urandom_range(0, 2), rd, rr);
      join
    end
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          p0;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; WTO = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rst_wden", {31'b0, WDEN}, 32'd0);
    checkOutput("rst_wtocnt", WTOCNT, 32'hFFFF_FFFF);
    checkOutput("rst_bvalid", {31'b0, BVALID}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, RVALID}, 32'd0);
    checkOutput("rst_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'd7);
    @(posedge ACLK);
    #1;
    ARESETn  = 1'b1;
    check_en = 1'b1;

    writeTxn(32'h0000_0300, 32'h0000_00AB, 4'b0001, 0, 0, 0, r);
    checkOutput("lit_wtocnt_byte", WTOCNT, 32'hFFFF_FFAB);
    checkOutput("lit_bresp_okay", {30'b0, r}, 32'd0);
    writeTxn(32'h0000_0500, 32'h1234_5678, 4'hF, 0, 0, 1, r);
    checkOutput("lit_bresp_slverr", {30'b0, r}, 32'd2);
    checkOutput("lit_wtocnt_kept", WTOCNT, 32'hFFFF_FFAB);
    writeTxn(32'h0000_0300, 32'h0000_0400, 4'hF, 0, 1, 3, r);
    checkOutput("lit_wtocnt_full", WTOCNT, 32'h0000_0400);

    p0 = pulse_cycles;
    writeTxn(32'h0000_0200, 32'h1, 4'hF, 0, 0, 1, r);
    checkOutput("lit_kick_one", pulse_cycles - p0, 32'd1);
    p0 = pulse_cycles;
    writeTxn(32'h0000_0200, 32'h0, 4'hF, 0, 0, 1, r);
    checkOutput("lit_kick_none", pulse_cycles - p0, 32'd0);

    WTO = 1'b1;
    readTxn(32'h0000_0400, 0, 1, d, r);
    checkOutput("lit_status", d, 32'd1);
    checkOutput("lit_status_resp", {30'b0, r}, 32'd0);
    WTO = 1'b0;
    writeTxn(32'h0000_0100, 32'h1, 4'hF, 1, 0, 0, r);
    readTxn(32'h0000_0100, 0, 0, d, r);
`ifdef WDT_READBACK_EN
    checkOutput("lit_wden_read", d, 32'd1);
`else
    checkOutput("lit_wden_read", d, 32'd0);
`endif
    readTxn(32'h0000_0200, 0, 0, d, r);
    checkOutput("lit_wdlive_read_resp", {30'b0, r}, 32'd2);

    for (int i = 0; i < 250; i++) applyStimulus();

    AWADDR = 32'h0000_0100; WDATA = 32'h1; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    m_wden = 1'b1;
    @(negedge ACLK);
    checkOutput("pre_rst_bvalid", {31'b0, BVALID}, 32'd1);
    #2;
    ARESETn  = 1'b0;
    m_wden   = 1'b0;
    m_wtocnt = 32'hFFFF_FFFF;
    #1;
    checkOutput("mid_rst_bvalid", {31'b0, BVALID}, 32'd0);
    checkOutput("mid_rst_wden", {31'b0, WDEN}, 32'd0);
    checkOutput("mid_rst_wtocnt", WTOCNT, 32'hFFFF_FFFF);
    checkOutput("mid_rst_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'd7);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("post_rst_bvalid", {31'b0, BVALID}, 32'd0);
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    tests_failed++;
    $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
